// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared widths, BTB defaults and 2-bit counter encodings
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BTB_ENTRIES
`define BTB_ENTRIES 16
`endif
`ifndef BTB_IDX_W
`define BTB_IDX_W 4
`endif
package branch_predictor_pkg;
  localparam int PC_W = `PC_WIDTH;
  localparam int BTB_ENTRIES = `BTB_ENTRIES;
  localparam int BTB_IDX_W = `BTB_IDX_W;
  typedef logic [1:0] ctr_t;
  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;
endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating up/down counter
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       up_i,
  output logic [1:0] ctr_o
);
  always_comb ctr_o = up_i ? (ctr_i == ST ? ST : ctr_i + 2'd1)
                           : (ctr_i == SNT ? SNT : ctr_i - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, IF lookup, EX training
// and misprediction detection with redirect PC and resolution statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = BTB_IDX_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_branch,
  input  logic            ex_stall,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     mp_count
);
  localparam int TAG_W = PC_W - IDX_W - 2;
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [31:0]        br_q, br_d, mp_q, mp_d;
  logic [IDX_W-1:0]   if_idx, ex_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  logic               if_hit, ex_hit, train;
  logic [1:0]         ctr_upd;
  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];
  // valid gates the tag compare so uninitialised tags never leak into outputs
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign train  = ex_branch && !ex_stall;
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + PC_W'(4);
  assign mispredict  = train && ((ex_taken != ex_pred_taken) ||
                                 (ex_taken && ex_target != ex_pred_target));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + PC_W'(4);
  assign br_count = br_q;
  assign mp_count = mp_q;
  sat_counter2 u_ctr (
    .ctr_i (ctr_q[ex_idx]),
    .up_i  (ex_taken),
    .ctr_o (ctr_upd)
  );
  always_comb begin
    br_d = (train && ~&br_q) ? br_q + 32'd1 : br_q;
    mp_d = (mispredict && ~&mp_q) ? mp_q + 32'd1 : mp_q;
  end
  // a not-taken miss leaves the table untouched; a taken miss replaces the entry
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
      if (train && (ex_hit || ex_taken)) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        ctr_q[ex_idx]   <= ex_hit ? ctr_upd : WT;
        if (ex_taken) tgt_q[ex_idx] <= ex_target;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors with hand-computed expectations
module tb_branch_predictor;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] if_pc = 0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_branch = 0, ex_stall = 0, ex_taken = 0, ex_pred_taken = 0;
  logic [31:0] ex_pc = 0, ex_target = 0, ex_pred_target = 0;
  logic        mispredict;
  logic [31:0] redirect_pc, br_count, mp_count;
  int total = 0, bad = 0;
  int exp_br = 0, exp_mp = 0;
  always #5 clk = ~clk;
  branch_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_branch(ex_branch), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .br_count(br_count), .mp_count(mp_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic look(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    if_pc = pc;
    #1;
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, tk});
    chk("pred_target", pred_target, tgt);
  endtask
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt,
                         input logic mp, input logic [31:0] redir);
    ex_branch = 1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
    chk("mispredict", {31'd0, mispredict}, {31'd0, mp});
    if (mp) chk("redirect_pc", redirect_pc, redir);
    step();
    ex_branch = 0;
    exp_br++;
    if (mp) exp_mp++;
    chk("br_count", br_count, exp_br);
    chk("mp_count", mp_count, exp_mp);
  endtask
  initial begin
    step();
    step();
    rst = 0;
    look(32'h100, 0, 32'h104);
    chk("br_rst", br_count, 0);
    chk("mp_rst", mp_count, 0);
    resolve(32'h100, 1, 32'h080, 0, 32'h104, 1, 32'h080);
    look(32'h100, 1, 32'h080);
    resolve(32'h100, 0, 32'h080, 1, 32'h080, 1, 32'h104);
    look(32'h100, 0, 32'h104);
    resolve(32'h100, 0, 32'h080, 0, 32'h104, 0, 0);
    resolve(32'h100, 0, 32'h080, 0, 32'h104, 0, 0);
    resolve(32'h100, 1, 32'h080, 0, 32'h104, 1, 32'h080);
    look(32'h100, 0, 32'h104);
    resolve(32'h100, 1, 32'h080, 0, 32'h104, 1, 32'h080);
    look(32'h100, 1, 32'h080);
    resolve(32'h100, 1, 32'h080, 1, 32'h080, 0, 0);
    look(32'h140, 0, 32'h144);
    resolve(32'h140, 1, 32'h300, 0, 32'h144, 1, 32'h300);
    look(32'h140, 1, 32'h300);
    look(32'h100, 0, 32'h104);
    resolve(32'h180, 0, 32'h400, 0, 32'h184, 0, 0);
    look(32'h180, 0, 32'h184);
    look(32'h140, 1, 32'h300);
    ex_branch = 1; ex_stall = 1; ex_pc = 32'h140; ex_taken = 0;
    ex_target = 32'h300; ex_pred_taken = 1; ex_pred_target = 32'h300;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_mp", {31'd0, mispredict}, 0);
      step();
    end
    chk("stall_br", br_count, exp_br);
    look(32'h140, 1, 32'h300);
    ex_stall = 0;
    #1;
    chk("unstall_mp", {31'd0, mispredict}, 1);
    chk("unstall_redir", redirect_pc, 32'h144);
    step();
    ex_branch = 0;
    exp_br++;
    exp_mp++;
    chk("unstall_br", br_count, exp_br);
    chk("unstall_mpc", mp_count, exp_mp);
    look(32'h140, 0, 32'h144);
    resolve(32'h204, 1, 32'h200, 0, 32'h208, 1, 32'h200);
    look(32'h204, 1, 32'h200);
    ex_branch = 1; ex_pc = 32'h204; ex_taken = 1; ex_target = 32'h240;
    ex_pred_taken = 1; ex_pred_target = 32'h200;
    look(32'h204, 1, 32'h200);
    chk("tgt_mp", {31'd0, mispredict}, 1);
    chk("tgt_redir", redirect_pc, 32'h240);
    step();
    ex_branch = 0;
    look(32'h204, 1, 32'h240);
    chk("tgt_mpc", mp_count, exp_mp + 1);
    ex_branch = 1; ex_pc = 32'h100; ex_taken = 1; ex_target = 32'h500;
    ex_pred_taken = 0;
    rst = 1;
    step();
    rst = 0;
    ex_branch = 0;
    look(32'h204, 0, 32'h208);
    look(32'h100, 0, 32'h104);
    chk("rst2_br", br_count, 0);
    chk("rst2_mp", mp_count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
